// File: rtl/add_mul_sgn_arb_if.sv
// add_mul_sgn_arb_if
//   Bundles the request and result channels of add_mul_sgn_arb.
//   Handshake: a transfer happens on a rising CLK edge where the valid bit
//   and its ready bit are both 1. Valid may be dropped without a transfer
//   (requesters are not required to hold it), and ready never waits on a
//   later cycle's valid.
//   Signals:
//     REQ_VLD[nReq]        request valid, one bit per requester
//     REQ_RDY[nReq]        request accepted this cycle, one-hot or zero
//     REQ_XS/REQ_XC        packed XS/XC operands, requester i at slice i
//     REQ_Y                packed Y operands, requester i at slice i
//     P_VLD / P_RDY        result valid / result consumer ready
//     P, P_ID              signed product and issuing requester index
//     BUSY                 any operation held in the pipeline
//     P_OVF                XS+XC overflow flag (ADD_MUL_SGN_ARB_OVF_EN only)
//   master: requester/consumer side.  slave: arbiter side.
interface add_mul_sgn_arb_if #(
  parameter int widthX = 8,
  parameter int widthY = 8,
  parameter int nReq   = 4
);
  localparam int widthP = widthX + widthY;
  localparam int widthI = (nReq > 2) ? $clog2(nReq) : 1;

  logic [nReq-1:0]        REQ_VLD;
  logic [nReq-1:0]        REQ_RDY;
  logic [nReq*widthX-1:0] REQ_XS;
  logic [nReq*widthX-1:0] REQ_XC;
  logic [nReq*widthY-1:0] REQ_Y;
  logic                   P_VLD;
  logic                   P_RDY;
  logic [widthP-1:0]      P;
  logic [widthI-1:0]      P_ID;
  logic                   BUSY;
`ifdef ADD_MUL_SGN_ARB_OVF_EN
  logic                   P_OVF;

  modport master (
    output REQ_VLD, REQ_XS, REQ_XC, REQ_Y, P_RDY,
    input  REQ_RDY, P_VLD, P, P_ID, BUSY, P_OVF
  );
  modport slave (
    input  REQ_VLD, REQ_XS, REQ_XC, REQ_Y, P_RDY,
    output REQ_RDY, P_VLD, P, P_ID, BUSY, P_OVF
  );
`else
  modport master (
    output REQ_VLD, REQ_XS, REQ_XC, REQ_Y, P_RDY,
    input  REQ_RDY, P_VLD, P, P_ID, BUSY
  );
  modport slave (
    input  REQ_VLD, REQ_XS, REQ_XC, REQ_Y, P_RDY,
    output REQ_RDY, P_VLD, P, P_ID, BUSY
  );
`endif
endinterface

// File: rtl/add_mul_sgn_arb.sv
// add_mul_sgn_arb
//   Round-robin arbiter in front of a 2-stage pipeline around one shared
//   signed adder-multiplier, P = (XS+XC)*Y truncated to widthX+widthY bits.
//   Stage 1 holds the granted operands and requester index; stage 2 holds
//   the product and index. Both stages advance independently so the
//   pipeline runs at one operation per cycle and absorbs one extra
//   operation when the consumer stalls.
//   Ports:
//     CLK   clock, all state on the rising edge
//     RSTN  asynchronous active-low reset
//     bus   add_mul_sgn_arb_if.slave (request and result channels)
//   Option: define ADD_MUL_SGN_ARB_OVF_EN to add the registered P_OVF flag.
//   speed selects the datapath form: 0 adds first and uses one multiplier,
//   nonzero multiplies XS and XC in parallel and adds the partial products.
module add_mul_sgn_arb #(
  parameter int widthX = 8,
  parameter int widthY = 8,
  parameter int nReq   = 4,
  parameter int speed  = 0
) (
  input logic             CLK,
  input logic             RSTN,
  add_mul_sgn_arb_if.slave bus
);
  localparam int widthP = widthX + widthY;
  localparam int widthI = (nReq > 2) ? $clog2(nReq) : 1;

  // pipeline state
  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic [widthI-1:0] ptr_q, ptr_d;
  logic [widthX-1:0] xs1_q, xc1_q;
  logic [widthY-1:0] y1_q;
  logic [widthI-1:0] id1_q;
  logic [widthP-1:0] p_q;
  logic [widthI-1:0] pid_q;

  // arbitration / control
  logic              gnt_found;
  logic [widthI-1:0] gnt_idx;
  logic              adv1, adv2;
  logic              accept;
  logic              load2;
  logic [nReq-1:0]   gnt_onehot;
  logic [widthX-1:0] xs_g, xc_g;
  logic [widthY-1:0] y_g;
  logic [widthP-1:0] p_dp;

  assign adv2   = ~v2_q | bus.P_RDY;
  assign adv1   = ~v1_q | adv2;
  assign accept = gnt_found & adv1;
  assign load2  = v1_q & adv2;

  // First valid requester at or after ptr_q, wrapping modulo nReq.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < nReq; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= nReq) idx = idx - nReq;
      if (!gnt_found && bus.REQ_VLD[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = widthI'(idx);
      end
    end
  end

  assign gnt_onehot = nReq'(1) << gnt_idx;
  assign xs_g = bus.REQ_XS[int'(gnt_idx)*widthX +: widthX];
  assign xc_g = bus.REQ_XC[int'(gnt_idx)*widthX +: widthX];
  assign y_g  = bus.REQ_Y[int'(gnt_idx)*widthY +: widthY];

  // Ready is forced low while reset is held so no transfer appears to
  // happen on an edge that the registers ignore.
  assign bus.REQ_RDY = (accept && RSTN) ? gnt_onehot : '0;

  always_comb begin
    v1_d  = adv1 ? gnt_found : v1_q;
    v2_d  = adv2 ? v1_q : v2_q;
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (int'(gnt_idx) == nReq - 1) ? '0 : widthI'(int'(gnt_idx) + 1);
    end
  end

  // Shared datapath. All arithmetic is done modulo 2^widthP, so both forms
  // give the same truncated product.
  generate
    if (speed == 0) begin : g_dp_add_first
      logic signed [widthX:0]   sum;
      logic signed [widthP-1:0] sum_x, y_x;
      assign sum   = $signed({xs1_q[widthX-1], xs1_q}) + $signed({xc1_q[widthX-1], xc1_q});
      assign sum_x = widthP'(sum);
      assign y_x   = widthP'($signed(y1_q));
      assign p_dp  = sum_x * y_x;
    end else begin : g_dp_parallel
      logic signed [widthP-1:0] xs_x, xc_x, y_x;
      assign xs_x = widthP'($signed(xs1_q));
      assign xc_x = widthP'($signed(xc1_q));
      assign y_x  = widthP'($signed(y1_q));
      assign p_dp = (xs_x * y_x) + (xc_x * y_x);
    end
  endgenerate

`ifdef ADD_MUL_SGN_ARB_OVF_EN
  logic signed [widthX:0] ovf_sum;
  logic                   ovf_dp;
  logic                   ovf_q;
  // The widthX+1 sum fits in widthX bits only when its top two bits agree.
  assign ovf_sum = $signed({xs1_q[widthX-1], xs1_q}) + $signed({xc1_q[widthX-1], xc1_q});
  assign ovf_dp  = ovf_sum[widthX] ^ ovf_sum[widthX-1];
  assign bus.P_OVF = ovf_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ovf_q <= 1'b0;
    end else if (load2) begin
      ovf_q <= ovf_dp;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ptr_q <= '0;
      xs1_q <= '0;
      xc1_q <= '0;
      y1_q  <= '0;
      id1_q <= '0;
      p_q   <= '0;
      pid_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      ptr_q <= ptr_d;
      if (accept) begin
        xs1_q <= xs_g;
        xc1_q <= xc_g;
        y1_q  <= y_g;
        id1_q <= gnt_idx;
      end
      if (load2) begin
        p_q   <= p_dp;
        pid_q <= id1_q;
      end
    end
  end

  assign bus.P_VLD = v2_q;
  assign bus.P     = p_q;
  assign bus.P_ID  = pid_q;
  assign bus.BUSY  = v1_q | v2_q;
endmodule

// File: tb/tb_add_mul_sgn_arb.sv
module tb_add_mul_sgn_arb;
  localparam int WX = 8;
  localparam int WY = 8;
  localparam int NR = 4;
  localparam int WP = WX + WY;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  add_mul_sgn_arb_if #(.widthX(WX), .widthY(WY), .nReq(NR)) bus ();
  add_mul_sgn_arb #(.widthX(WX), .widthY(WY), .nReq(NR), .speed(0)) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // Product and overflow straight from integer arithmetic.
  function automatic logic [WP-1:0] ref_p(logic [WX-1:0] xs, logic [WX-1:0] xc, logic [WY-1:0] y);
    int s, pr;
    s  = int'($signed(xs)) + int'($signed(xc));
    pr = s * int'($signed(y));
    return pr[WP-1:0];
  endfunction

  function automatic logic ref_ovf(logic [WX-1:0] xs, logic [WX-1:0] xc);
    int s;
    s = int'($signed(xs)) + int'($signed(xc));
    return (s > 127) || (s < -128);
  endfunction

  // Model: two holding slots with occupancy flags, round-robin pointer.
  logic          m_v1, m_v2;
  logic [WP-1:0] m_p1, m_p2;
  int            m_id1, m_id2;
  logic          m_o1, m_o2;
  int            m_ptr;
  int            n_acc, n_out;

  always @(negedge CLK) begin
    logic [NR-1:0] exp_rdy;
    int   g;
    logic found, a1, a2;
    if (!RSTN) begin
      m_v1 = 0; m_v2 = 0; m_ptr = 0; m_p2 = '0; m_id2 = 0; m_o2 = 0;
      n_acc = 0; n_out = 0;
      check("rst_rdy", 32'(bus.REQ_RDY), 0);
      check("rst_pvld", 32'(bus.P_VLD), 0);
      check("rst_busy", 32'(bus.BUSY), 0);
      check("rst_p", 32'(bus.P), 0);
      check("rst_pid", 32'(bus.P_ID), 0);
    end else begin
      a2 = !m_v2 || bus.P_RDY;
      a1 = !m_v1 || a2;
      found = 0; g = 0;
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (!found && bus.REQ_VLD[i]) begin found = 1; g = i; end
      end
      exp_rdy = (found && a1) ? NR'(1 << g) : '0;
      check("req_rdy", 32'(bus.REQ_RDY), 32'(exp_rdy));
      check("p_vld", 32'(bus.P_VLD), 32'(m_v2));
      check("busy", 32'(bus.BUSY), 32'(m_v1 | m_v2));
      if (m_v2) begin
        check("p", 32'(bus.P), 32'(m_p2));
        check("p_id", 32'(bus.P_ID), 32'(m_id2));
`ifdef ADD_MUL_SGN_ARB_OVF_EN
        check("p_ovf", 32'(bus.P_OVF), 32'(m_o2));
`endif
      end
      if (m_v2 && bus.P_RDY) n_out++;
      // state after the coming edge
      if (a2) begin
        m_v2 = m_v1;
        if (m_v1) begin m_p2 = m_p1; m_id2 = m_id1; m_o2 = m_o1; end
      end
      if (a1) begin
        m_v1 = found;
        if (found) begin
          m_p1  = ref_p(bus.REQ_XS[g*WX +: WX], bus.REQ_XC[g*WX +: WX], bus.REQ_Y[g*WY +: WY]);
          m_o1  = ref_ovf(bus.REQ_XS[g*WX +: WX], bus.REQ_XC[g*WX +: WX]);
          m_id1 = g;
          m_ptr = (g + 1) % NR;
          n_acc++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_req(int i, logic [WX-1:0] xs, logic [WX-1:0] xc, logic [WY-1:0] y);
    bus.REQ_VLD[i] = 1'b1;
    bus.REQ_XS[i*WX +: WX] = xs;
    bus.REQ_XC[i*WX +: WX] = xc;
    bus.REQ_Y[i*WY +: WY]  = y;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    RSTN = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.P_RDY = 1'b1;
    bus.REQ_VLD = '0;
    @(negedge CLK);
    while (bus.BUSY && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) check("drain_timeout", 32'(bus.BUSY), 0);
    @(posedge CLK); #1;
  endtask

  // Wait (bounded) for the next valid result and compare to literals.
  task automatic wait_p(string name, logic [WP-1:0] exp_p, int exp_id);
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus.P_VLD && n < 20) begin @(negedge CLK); n++; end
    if (n >= 20) check({name, "_timeout"}, 32'(bus.P_VLD), 1);
    else begin
      check(name, 32'(bus.P), 32'(exp_p));
      check({name, "_id"}, 32'(bus.P_ID), 32'(exp_id));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WP-1:0] held_p;
    bus.REQ_VLD = '0;
    bus.REQ_XS = '0;
    bus.REQ_XC = '0;
    bus.REQ_Y = '0;
    bus.P_RDY = 1'b1;
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    tick();

    // single request, latency
    set_req(0, 8'd3, 8'd4, 8'hFB);
    @(negedge CLK);
    check("t1_rdy", 32'(bus.REQ_RDY), 32'h1);
    @(posedge CLK); #1;
    bus.REQ_VLD = '0;
    @(negedge CLK);
    check("t1_early", 32'(bus.P_VLD), 0);
    @(negedge CLK);
    check("t1_vld", 32'(bus.P_VLD), 1);
    check("t1_p", 32'(bus.P), 32'h0000FFDD);
    check("t1_id", 32'(bus.P_ID), 0);
    drain();

    // all requesters valid: grant order and one result per cycle
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, WX'(i + 1), WX'(i), WY'(i + 2));
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check("rr_gnt", 32'(bus.REQ_RDY), 32'(1 << (k % 4)));
      if (k >= 2) begin
        check("rr_vld", 32'(bus.P_VLD), 1);
        check("rr_id", 32'(bus.P_ID), 32'((k - 2) % 4));
      end
      @(posedge CLK); #1;
    end
    drain();

    // backpressure with req1 and req2
    bus.P_RDY = 1'b0;
    set_req(1, 8'd10, 8'd5, 8'd3);
    set_req(2, 8'hF0, 8'd2, 8'd7);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (k == 2) held_p = bus.P;
      if (k == 4) begin
        check("bp_full_rdy", 32'(bus.REQ_RDY), 0);
        check("bp_p_held", 32'(bus.P), 32'(held_p));
      end
      @(posedge CLK); #1;
    end
    bus.REQ_VLD = '0;
    bus.P_RDY = 1'b1;
    wait_p("bp_first", WP'(45), 1);
    wait_p("bp_second", 16'hFF9E, 2);
    drain();

    // corner operands
    set_req(0, 8'h80, 8'h00, 8'h80);
    tick();
    bus.REQ_VLD = '0;
    wait_p("corner_neg", 16'h4000, 0);
    drain();
    set_req(0, 8'h7F, 8'h00, 8'h7F);
    tick();
    bus.REQ_VLD = '0;
    wait_p("corner_pos", 16'h3F01, 0);
    drain();

`ifdef ADD_MUL_SGN_ARB_OVF_EN
    set_req(0, 8'd100, 8'd100, 8'd1);
    tick();
    bus.REQ_VLD = '0;
    wait_p("ovf_p", 16'h00C8, 0);
    check("ovf_set", 32'(bus.P_OVF), 1);
    drain();
    set_req(0, 8'hC0, 8'hC0, 8'd3);
    tick();
    bus.REQ_VLD = '0;
    wait_p("ovf_p2", 16'hFE80, 0);
    check("ovf_clr", 32'(bus.P_OVF), 0);
    drain();
`endif

    // asynchronous reset with both stages full
    bus.P_RDY = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, WX'(i + 7), 8'd1, 8'd2);
    repeat (4) tick();
    @(posedge CLK); #3;
    RSTN = 1'b0;
    #1;
    check("arst_pvld", 32'(bus.P_VLD), 0);
    check("arst_busy", 32'(bus.BUSY), 0);
    check("arst_rdy", 32'(bus.REQ_RDY), 0);
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    bus.P_RDY = 1'b1;
    @(negedge CLK);
    check("arst_ptr0", 32'(bus.REQ_RDY), 32'h1);
    @(posedge CLK); #1;
    bus.REQ_VLD = '0;
    wait_p("arst_after", WP'(16), 0);
    drain();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.REQ_VLD = NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          bus.REQ_XS[i*WX +: WX] = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
          bus.REQ_Y[i*WY +: WY]  = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
        end else begin
          bus.REQ_XS[i*WX +: WX] = WX'($urandom);
          bus.REQ_Y[i*WY +: WY]  = WY'($urandom);
        end
        bus.REQ_XC[i*WX +: WX] = WX'($urandom);
      end
      bus.P_RDY = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    @(negedge CLK);
    check("conserve", 32'(n_out), 32'(n_acc));
    check("final_busy", 32'(bus.BUSY), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
